rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter with grant locking and optional hold timeout.
- Shares one downstream resource, such as a memory port or bus slave in the npc core, between up to four masters.
- Holds the winner as a 2-bit index and drives a registered one-hot grant vector.
- One-hot generation goes through the team's existing decoder_2to4_onehot.

Parameters:
- MAX_HOLD, 16: max consecutive cycles one requester may hold the grant while others wait; 0 disables the timeout.
- CNT_W, 5: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request per master; held high for the whole transaction
- gnt  output  4  one-hot grant, registered; all zero when idle
- gnt_id  output  2  index of current owner; valid only when gnt_valid=1
- gnt_valid  output  1  high while any grant is active (equals OR of gnt)
- preempt  output  1  one-cycle pulse in the cycle after a timeout forced a switch

Behaviour:
- States: IDLE and GRANT, plus registers owner[1:0], last[1:0], hold_cnt[CNT_W-1:0].
- Reset (rst=1 at an edge):
  - state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, preempt=0, hold_cnt=0.
  - last=3, so master 0 has top priority after reset.
  - Reset mid-grant drops gnt in the following cycle with no handshake.
- Pick function (combinational): first set bit of req, searching from index last+1 upward with wrap (mod 4).
  - Search on timeout excludes the current owner.
- IDLE:
  - If any req bit is set at edge t: state=GRANT, owner=pick, hold_cnt=0.
  - gnt reflects the new owner from cycle t+1, giving 1-cycle grant latency.
  - If no req: stay IDLE.
- GRANT, release: req[owner]=0 at an edge.
  - last=owner.
  - Pick among the remaining reqs, searching from owner+1. If one is found, the new owner is granted next cycle back-to-back with no idle gap; otherwise state=IDLE and gnt=0.
- GRANT, timeout: MAX_HOLD!=0, req[owner]=1, hold_cnt==MAX_HOLD-1, and some other req is set.
  - Switch to pick(excluding owner), last=owner, hold_cnt=0.
  - preempt=1 for exactly the next cycle.
- GRANT, otherwise:
  - Keep owner; hold_cnt increments, saturating at MAX_HOLD-1.
  - With no competitors, the owner keeps the grant indefinitely.
- gnt changes only at clock edges and is never more than one-hot, including during switches.
- Request timing:
  - A req rising in the same cycle as a release is considered in that cycle's pick.
  - Requests deasserted before they are granted are simply dropped; no queueing.
- Simultaneous release plus timeout condition: release takes precedence and preempt stays 0.

Decomposition:
- No shared package is required.
- Local constants: state encoding (IDLE=1'b0, GRANT=1'b1), NUM_REQ=4.
- Sub-modules:
  - gnt is produced by instantiating decoder_2to4_onehot(a=owner_next, en=grant_next) and registering its output.
  - The rotate-and-pick logic is a natural separate combinational sub-module, rr_pick4, with inputs req[3:0], start[1:0], mask[3:0] and outputs found and idx[1:0].

Test Plan:
- Reset, then req=4'b1111 held -> cycle 1: gnt=0001, gnt_id=0. After the owner drops req for one cycle each time, grants go 0010, 0100, 1000, 0001 in turn.
- req=0100 alone, held 100 cycles, MAX_HOLD=16 -> gnt=0100 continuously, preempt never asserted.
- req=0011, master 0 never releases, MAX_HOLD=16 -> gnt=0001 for 16 cycles, then gnt=0010 with preempt=1 for one cycle. Master 0 regains the grant 16 cycles later.
- Owner 2 releases in the same cycle master 1 raises req (req 0100 -> 0010) -> next cycle gnt=0010 with no idle cycle between.
- rst asserted while gnt=1000 -> next cycle gnt=0000 and gnt_valid=0. With req=1001 after reset, master 0 is granted first.
- Release coinciding with a timeout (MAX_HOLD=4, req 0001 -> 0010 at count 3) -> gnt=0010 and preempt=0; all gnt values are checked one-hot-or-zero every cycle.

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// Shared constants and state encoding for the 4-way round-robin arbiter.
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the masters and the arbiter.
interface rr_arbiter_4_if;
  import rr_arbiter_4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_id;
  logic               gnt_valid;
  logic               preempt;

  // master side drives requests and watches grants
  modport master (output req, input gnt, gnt_id, gnt_valid, preempt);
  // arbiter side
  modport slave  (input req, output gnt, gnt_id, gnt_valid, preempt);
endinterface

// File: rtl/decoder_2to4_onehot.sv
// 2-to-4 one-hot decoder with enable; all-zero output when disabled.
module decoder_2to4_onehot (
  input  logic [1:0] a,
  input  logic       en,
  output logic [3:0] y
);

  // one bit per code, gated by en
  always_comb begin
    y = '0;
    for (int i = 0; i < 4; i++) begin
      y[i] = en && (a == 2'(i));
    end
  end

endmodule

// File: rtl/rr_pick4.sv
// Rotating priority pick: first unmasked request at or after start, wrapping mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  input  logic [3:0] mask,
  output logic       found,
  output logic [1:0] idx
);

  logic [3:0] eff;
  logic [1:0] cand;

  assign eff = req & ~mask;

  // walk the four positions from start; the first hit wins
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int i = 0; i < 4; i++) begin
      cand = start + 2'(i);
      if (!found && eff[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant locking and hold timeout.
// The owner keeps the grant while its req stays high; after MAX_HOLD cycles
// with someone else waiting it is forced off and preempt pulses once.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input logic           clk,
  input logic           rst,
  rr_arbiter_4_if.slave bus
);

  // last count value before a timeout; pinned at 0 when the timeout is off
  localparam logic [CNT_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 preempt_q, preempt_d;

  logic [IDX_W-1:0]     pick_start;
  logic [NUM_REQ-1:0]   pick_mask;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 grant_next;
  logic                 at_lim;

  // while granted, search after the owner and never re-pick it;
  // when idle, search after the last released owner
  always_comb begin
    if (state_q == ST_GRANT) begin
      pick_start = owner_q + 2'd1;
      pick_mask  = 4'b0001 << owner_q;
    end else begin
      pick_start = last_q + 2'd1;
      pick_mask  = '0;
    end
  end

  rr_pick4 u_pick (
    .req   (bus.req),
    .start (pick_start),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign at_lim = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);

  // next-state: acquire from idle, release (wins over timeout), timeout, or hold
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (!bus.req[owner_q]) begin
          last_d     = owner_q;
          hold_cnt_d = '0;
          if (pick_found) owner_d = pick_idx;
          else            state_d = ST_IDLE;
        end else if (at_lim && pick_found) begin
          last_d     = owner_q;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
          preempt_d  = 1'b1;
        end else if (hold_cnt_q != HOLD_LIM) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_next = (state_d == ST_GRANT);

  decoder_2to4_onehot u_dec (
    .a  (owner_d),
    .en (grant_next),
    .y  (gnt_d)
  );

  // state and registered grant outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = owner_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench: dut_a uses MAX_HOLD=16, dut_b uses MAX_HOLD=4.
module tb_rr_arbiter_4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rr_arbiter_4_if ifa ();
  rr_arbiter_4_if ifb ();

  rr_arbiter_4 #(.MAX_HOLD(16), .CNT_W(5)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  rr_arbiter_4 #(.MAX_HOLD(4),  .CNT_W(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // outputs settle #1 after the edge; inputs are changed there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // every cycle: grant never more than one-hot, valid tracks grant
  always @(negedge clk) begin
    chk("onehot_a", 32'($onehot0(ifa.gnt)), 1);
    chk("onehot_b", 32'($onehot0(ifb.gnt)), 1);
    chk("valid_a",  32'(ifa.gnt_valid), 32'(|ifa.gnt));
  end

  initial begin
    int         cur;
    logic [3:0] e;
    ifa.req = '0;
    ifb.req = '0;
    rst     = 1'b1;
    step();
    step();
    chk("rst_gnt",     ifa.gnt, 0);
    chk("rst_id",      ifa.gnt_id, 0);
    chk("rst_valid",   ifa.gnt_valid, 0);
    chk("rst_preempt", ifa.preempt, 0);

    // round-robin rotation with all masters requesting
    rst     = 1'b0;
    ifa.req = 4'b1111;
    step();
    chk("first_gnt", ifa.gnt, 4'b0001);
    chk("first_id",  ifa.gnt_id, 0);
    chk("first_vld", ifa.gnt_valid, 1);
    cur = 0;
    for (int k = 0; k < 4; k++) begin
      e = 4'b0001 << cur;
      ifa.req = 4'b1111 & ~e;
      step();
      cur = (cur + 1) % 4;
      e   = 4'b0001 << cur;
      chk("rot_gnt", ifa.gnt, e);
      chk("rot_id",  ifa.gnt_id, cur);
      ifa.req = 4'b1111;
      step();
      chk("rot_hold", ifa.gnt, e);
    end
    ifa.req = 4'b0000;
    step();
    chk("idle_gnt", ifa.gnt, 0);
    chk("idle_vld", ifa.gnt_valid, 0);

    // lone requester holds indefinitely, no preempt
    ifa.req = 4'b0100;
    step();
    for (int k = 0; k < 100; k++) begin
      chk("solo_gnt", ifa.gnt, 4'b0100);
      chk("solo_pre", ifa.preempt, 0);
      step();
    end

    // release and new request in the same cycle: back-to-back switch
    ifa.req = 4'b0010;
    step();
    chk("b2b_gnt", ifa.gnt, 4'b0010);
    chk("b2b_id",  ifa.gnt_id, 1);
    ifa.req = 4'b0000;
    step();
    chk("b2b_idle", ifa.gnt, 0);

    // timeout: master 0 holds 16 cycles, then forced to master 1 and back
    ifa.req = 4'b0011;
    step();
    for (int k = 0; k < 16; k++) begin
      chk("to_hold0", ifa.gnt, 4'b0001);
      chk("to_pre0",  ifa.preempt, 0);
      if (k < 15) step();
    end
    step();
    chk("to_sw1",  ifa.gnt, 4'b0010);
    chk("to_pre1", ifa.preempt, 1);
    for (int k = 0; k < 15; k++) begin
      step();
      chk("to_hold1", ifa.gnt, 4'b0010);
      chk("to_pre1z", ifa.preempt, 0);
    end
    step();
    chk("to_sw0",   ifa.gnt, 4'b0001);
    chk("to_pre0b", ifa.preempt, 1);

    // reset mid-grant, then master 0 has top priority again
    ifa.req = 4'b1000;
    step();
    chk("pre_rst_gnt", ifa.gnt, 4'b1000);
    rst = 1'b1;
    step();
    chk("mid_rst_gnt", ifa.gnt, 0);
    chk("mid_rst_vld", ifa.gnt_valid, 0);
    rst     = 1'b0;
    ifa.req = 4'b1001;
    step();
    chk("post_rst_gnt", ifa.gnt, 4'b0001);
    chk("post_rst_id",  ifa.gnt_id, 0);

    // release coinciding with timeout on dut_b (MAX_HOLD=4)
    ifb.req = 4'b0001;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("rt_hold", ifb.gnt, 4'b0001);
      if (k < 3) step();
    end
    ifb.req = 4'b0010;
    step();
    chk("rt_gnt", ifb.gnt, 4'b0010);
    chk("rt_id",  ifb.gnt_id, 1);
    chk("rt_pre", ifb.preempt, 0);
    step();
    chk("rt_pre2", ifb.preempt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
